// File: rtl/icache_pkg.sv
// Shared defaults, derived address-field widths and FSM states for the instruction cache array.
package icache_pkg;

    localparam int DATA_LENGTH_DEF = 32;
    localparam int LINE_SIZE_DEF   = 64;
    localparam int NUM_LINES_DEF   = 64;

    localparam int WORDS_DEF     = LINE_SIZE_DEF * 8 / DATA_LENGTH_DEF;
    localparam int OFFSET_W_DEF  = $clog2(WORDS_DEF);
    localparam int INDEX_W_DEF   = $clog2(NUM_LINES_DEF);
    localparam int LINE_BITS_DEF = $clog2(LINE_SIZE_DEF);
    localparam int TAG_W_DEF     = 32 - LINE_BITS_DEF - INDEX_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Line data storage: combinational read port for zero-latency hits, synchronous refill write port.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter int NUM_LINES   = NUM_LINES_DEF,
    parameter int WORDS       = WORDS_DEF,
    parameter int INDEX_W     = $clog2(NUM_LINES),
    parameter int OFFSET_W    = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [INDEX_W-1:0]     wr_line,
    input  logic [OFFSET_W-1:0]    wr_word,
    input  logic [DATA_LENGTH-1:0] wr_data,
    input  logic [INDEX_W-1:0]     rd_line,
    input  logic [OFFSET_W-1:0]    rd_word,
    output logic [DATA_LENGTH-1:0] rd_data
);

    logic [DATA_LENGTH-1:0] mem_r [NUM_LINES][WORDS];

    // Refill write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_line][wr_word] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_line][rd_word];

endmodule

// File: rtl/icache_array.sv
// Direct-mapped instruction cache array with line-fill FSM.
// Optional ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_array
    import icache_pkg::*;
#(
    parameter int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter int LINE_SIZE   = LINE_SIZE_DEF,
    parameter int NUM_LINES   = NUM_LINES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic [31:0]            addr_in,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   miss,
    input  logic                   refill_valid,
    input  logic [DATA_LENGTH-1:0] refill_data,
    output logic                   refill_complete,
    input  logic                   flush
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    localparam int WORDS     = LINE_SIZE * 8 / DATA_LENGTH;
    localparam int OFFSET_W  = $clog2(WORDS);
    localparam int INDEX_W   = $clog2(NUM_LINES);
    localparam int LINE_BITS = $clog2(LINE_SIZE);
    localparam int TAG_W     = 32 - LINE_BITS - INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS - 1);

    state_t                state_r;
    state_t                state_nx_s;
    logic [OFFSET_W-1:0]   cnt_r;
    logic [INDEX_W-1:0]    fill_idx_r;
    logic [TAG_W-1:0]      fill_tag_r;
    logic [NUM_LINES-1:0]  valid_r;
    logic [TAG_W-1:0]      tag_ram_r [NUM_LINES];
    logic                  refill_complete_r;

    logic [OFFSET_W-1:0]   offset_s;
    logic [INDEX_W-1:0]    index_s;
    logic [TAG_W-1:0]      tag_s;
    logic                  hit_s;
    logic                  lookup_miss_s;
    logic                  miss_s;
    logic                  wr_en_s;
    logic                  last_s;
    logic                  unused_addr_s;

    assign offset_s      = addr_in[LINE_BITS-1 -: OFFSET_W];
    assign index_s       = addr_in[LINE_BITS +: INDEX_W];
    assign tag_s         = addr_in[31 -: TAG_W];
    assign unused_addr_s = ^addr_in[1:0];

    assign hit_s         = valid_r[index_s] && (tag_ram_r[index_s] == tag_s);
    assign lookup_miss_s = rd_en && !hit_s;

    // Next-state, miss and array-write decode; flush overrides everything.
    always_comb begin
        state_nx_s = state_r;
        miss_s     = 1'b1;
        wr_en_s    = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                miss_s = lookup_miss_s;
                if (lookup_miss_s) begin
                    state_nx_s = FILL;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FILL: begin
                if (refill_valid) begin
                    wr_en_s = 1'b1;
                    if (cnt_r == LAST_WORD) begin
                        last_s     = 1'b1;
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = FILL;
                    end
                end else begin
                    state_nx_s = FILL;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        if (flush) begin
            state_nx_s = IDLE;
            wr_en_s    = 1'b0;
            last_s     = 1'b0;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // Miss is forced low while reset is held so rd_en cannot leak through.
    assign miss            = rst & miss_s;
    assign refill_complete = refill_complete_r;

    // FSM state, fill bookkeeping and valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r           <= IDLE;
            cnt_r             <= '0;
            fill_idx_r        <= '0;
            fill_tag_r        <= '0;
            valid_r           <= '0;
            refill_complete_r <= 1'b0;
        end else begin
            state_r           <= state_nx_s;
            refill_complete_r <= last_s;
            if (flush) begin
                valid_r <= '0;
                cnt_r   <= '0;
            end else if (state_r == IDLE && lookup_miss_s) begin
                fill_idx_r       <= index_s;
                fill_tag_r       <= tag_s;
                valid_r[index_s] <= 1'b0;
                cnt_r            <= '0;
            end else if (wr_en_s) begin
                cnt_r <= last_s ? '0 : cnt_r + OFFSET_W'(1);
                if (last_s) begin
                    valid_r[fill_idx_r] <= 1'b1;
                end
            end
        end
    end

    // Tag write at line completion; tag contents are not reset.
    always_ff @(posedge clk) begin
        if (last_s) begin
            tag_ram_r[fill_idx_r] <= fill_tag_r;
        end
    end

    icache_data_ram #(
        .DATA_LENGTH (DATA_LENGTH),
        .NUM_LINES   (NUM_LINES),
        .WORDS       (WORDS)
    ) u_data_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_line (fill_idx_r),
        .wr_word (cnt_r),
        .wr_data (refill_data),
        .rd_line (index_s),
        .rd_word (offset_s),
        .rd_data (data_out)
    );

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Lookup statistics, counted only for lookups decided in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else if (flush) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else if (state_r == IDLE && rd_en) begin
            if (hit_s) begin
                hit_count_r <= sat_inc32(hit_count_r);
            end else begin
                miss_count_r <= sat_inc32(miss_count_r);
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_icache_array.sv
// Scoreboard bench for icache_array: stimulus queues expected outputs, a negedge monitor compares them.
module tb_icache_array;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [31:0] addr_in;
    logic [31:0] data_out;
    logic        miss;
    logic        refill_valid;
    logic [31:0] refill_data;
    logic        refill_complete;
    logic        flush;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_array dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .addr_in         (addr_in),
        .data_out        (data_out),
        .miss            (miss),
        .refill_valid    (refill_valid),
        .refill_data     (refill_data),
        .refill_complete (refill_complete),
        .flush           (flush)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        miss;
        logic        rc;
        logic        chk_data;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic probe;
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: every probed cycle pops one expectation and compares outputs.
    always @(negedge clk) begin
        if (probe) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: probed cycle with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                n_checks++;
                if (miss !== mon_e.miss) begin
                    n_errors++;
                    $display("FAIL %s.miss: got %0b expected %0b", mon_e.name, miss, mon_e.miss);
                end
                n_checks++;
                if (refill_complete !== mon_e.rc) begin
                    n_errors++;
                    $display("FAIL %s.refill_complete: got %0b expected %0b", mon_e.name,
                             refill_complete, mon_e.rc);
                end
                if (mon_e.chk_data) begin
                    n_checks++;
                    if (data_out !== mon_e.data) begin
                        n_errors++;
                        $display("FAIL %s.data_out: got %h expected %h", mon_e.name, data_out,
                                 mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rd_en        = 1'b0;
        addr_in      = 32'h0;
        refill_valid = 1'b0;
        refill_data  = 32'h0;
        flush        = 1'b0;
        probe        = 1'b0;
    endtask

    task automatic expect_out(input logic m, input logic rc, input logic chk, input logic [31:0] d,
                              input string name);
        exp_t e;
        e.miss     = m;
        e.rc       = rc;
        e.chk_data = chk;
        e.data     = d;
        e.name     = name;
        probe      = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic lookup(input logic [31:0] a, input logic m, input logic chk, input logic [31:0] d,
                          input string name);
        tick();
        clr();
        rd_en   = 1'b1;
        addr_in = a;
        expect_out(m, 1'b0, chk, d, name);
    endtask

    // Feed n words with a gap cycle after each; gap cycles are probed.
    task automatic feed(input logic [31:0] base, input int n, input bit flush_last);
        for (int i = 0; i < n; i++) begin
            tick();
            clr();
            refill_valid = 1'b1;
            refill_data  = base + 32'(i);
            if (flush_last && i == n - 1) flush = 1'b1;
            tick();
            clr();
            if (flush_last && i == n - 1)
                expect_out(1'b0, 1'b0, 1'b0, 32'h0, "flush_abort_idle");
            else if (i == 15)
                expect_out(1'b1, 1'b1, 1'b0, 32'h0, "refill_pulse");
            else
                expect_out(1'b1, 1'b0, 1'b0, 32'h0, "fill_hold");
        end
    endtask

    task automatic fill_entry();
        tick();
        clr();
        expect_out(1'b1, 1'b0, 1'b0, 32'h0, "fill_entry");
    endtask

    task automatic chk_stats(input logic [31:0] h, input logic [31:0] m, input string name);
`ifdef ICACHE_STATS_EN
        n_checks++;
        if (hit_count !== h) begin
            n_errors++;
            $display("FAIL %s.hit_count: got %0d expected %0d", name, hit_count, h);
        end
        n_checks++;
        if (miss_count !== m) begin
            n_errors++;
            $display("FAIL %s.miss_count: got %0d expected %0d", name, miss_count, m);
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        clr();
        tick();
        tick();
        rd_en   = 1'b1;
        addr_in = 32'h0000_1040;
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, "reset_miss_gated");
        tick();
        rst = 1'b1;
        clr();
        chk_stats(32'd0, 32'd0, "stats_reset");

        // Cold miss, fill with gapped refill words, then hits.
        lookup(32'h0000_1040, 1'b1, 1'b0, 32'h0, "cold_miss");
        fill_entry();
        feed(32'hA000_0000, 16, 1'b0);
        lookup(32'h0000_1048, 1'b0, 1'b1, 32'hA000_0002, "hit_word2");
        lookup(32'h0000_107C, 1'b0, 1'b1, 32'hA000_000F, "hit_last_word");
        lookup(32'h0000_1040, 1'b0, 1'b1, 32'hA000_0000, "hit_word0");

        // Conflict miss on index 1 replaces the resident line.
        lookup(32'h0002_1040, 1'b1, 1'b0, 32'h0, "conflict_miss");
        fill_entry();
        feed(32'hB000_0000, 16, 1'b0);
        lookup(32'h0002_1044, 1'b0, 1'b1, 32'hB000_0001, "hit_new_tag");
        lookup(32'h0000_1040, 1'b1, 1'b0, 32'h0, "old_tag_miss");
        fill_entry();

        // Flush with the final refill word aborts the fill.
        feed(32'hC000_0000, 16, 1'b1);
        lookup(32'h0000_1040, 1'b1, 1'b0, 32'h0, "miss_after_flush");
        fill_entry();

        // Reset in the middle of a fill.
        feed(32'hD000_0000, 8, 1'b0);
        tick();
        rst = 1'b0;
        clr();
        rd_en   = 1'b1;
        addr_in = 32'h0000_1040;
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, "reset_midfill_gated");
        tick();
        rst = 1'b1;
        clr();
        rd_en   = 1'b1;
        addr_in = 32'h0000_1040;
        expect_out(1'b1, 1'b0, 1'b0, 32'h0, "miss_after_reset");
        fill_entry();
        feed(32'hE000_0000, 16, 1'b0);
        lookup(32'h0000_1040, 1'b0, 1'b1, 32'hE000_0000, "hit_after_refill0");
        lookup(32'h0000_107C, 1'b0, 1'b1, 32'hE000_000F, "hit_after_refill15");
        lookup(32'h0000_1044, 1'b0, 1'b1, 32'hE000_0001, "hit_after_refill1");
        tick();
        clr();
        chk_stats(32'd3, 32'd1, "stats_3h1m");

        // refill_valid while IDLE must not write the array.
        lookup(32'h0000_1040, 1'b0, 1'b1, 32'hE000_0000, "idle_refill_ignored");
        refill_valid = 1'b1;
        refill_data  = 32'hDEAD_BEEF;
        lookup(32'h0000_1040, 1'b0, 1'b1, 32'hE000_0000, "idle_refill_no_write");

        // Flush coincident with an IDLE miss: no fill entry.
        lookup(32'h0000_3040, 1'b1, 1'b0, 32'h0, "flush_with_miss");
        flush = 1'b1;
        tick();
        clr();
        expect_out(1'b0, 1'b0, 1'b0, 32'h0, "no_fill_after_flush");
        chk_stats(32'd0, 32'd0, "stats_flushed");
        lookup(32'h0000_1040, 1'b1, 1'b0, 32'h0, "flush_invalidated");
        tick();
        clr();
        tick();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_array.md
ICACHE_ARRAY -- requirements
Module: icache_array

Interface
REQ-001 Parameters: DATA_LENGTH, default 32, instruction/refill word width in bits; LINE_SIZE, default 64, line size in bytes; NUM_LINES, default 64, number of direct-mapped lines.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low clears state immediately, release synchronous to clk.
REQ-004 rd_en  input  1  lookup request valid this cycle.
REQ-005 addr_in  input  32  byte address of the requested instruction.
REQ-006 data_out  output  DATA_LENGTH  instruction word for addr_in; valid when rd_en=1 and miss=0.
REQ-007 miss  output  1  lookup did not hit, or a line fill is in progress.
REQ-008 refill_valid  input  1  refill_data carries the next sequential word of the pending line.
REQ-009 refill_data  input  DATA_LENGTH  refill word from the fetch controller.
REQ-010 refill_complete  output  1  single-cycle pulse; last word of the line written.
REQ-011 flush  input  1  invalidate all lines and abort any fill.

Function
REQ-012 WORDS = LINE_SIZE*8/DATA_LENGTH (16 at defaults); offset = addr_in[log2(LINE_SIZE)-1:2]; index = next log2(NUM_LINES) bits; tag = remaining upper bits (20 at defaults).
REQ-013 States: IDLE, FILL, DONE.
REQ-014 IDLE: miss = rd_en & ~(valid[index] & tag_ram[index]==tag), combinational; data_out = data_ram[index][offset], combinational, zero-latency hit.
REQ-015 IDLE and miss=1 -> FILL next cycle; latch index and tag; clear valid[index]; word counter = 0.
REQ-016 FILL: miss held 1 regardless of rd_en/addr_in; each cycle with refill_valid=1 writes refill_data to data_ram[latched index][counter] and increments counter.
REQ-017 FILL and refill_valid=1 with counter=WORDS-1 -> write tag, set valid, go DONE; refill_complete=1 during DONE only.
REQ-018 DONE -> IDLE unconditionally after one cycle; miss=1 during DONE; re-lookup occurs in IDLE.
REQ-019 refill_valid in IDLE or DONE is ignored; no array write.
REQ-020 flush=1 in any state: all valid bits cleared next edge, state -> IDLE, counter -> 0, no refill_complete.
REQ-021 flush coincident with last refill word: flush wins; line stays invalid; no refill_complete pulse.
REQ-022 flush coincident with an IDLE miss: no FILL entry.
REQ-023 Counter width log2(WORDS); never wraps in FILL (exit at WORDS-1).

Reset
REQ-024 rst low: state=IDLE, counter=0, all valid bits 0, refill_complete=0, miss=0 (rd_en gated), stats counters 0; data/tag RAM contents not reset.
REQ-025 rst asserted mid-FILL: fill abandoned; no partial line becomes valid.

Configuration
REQ-026 Macro ICACHE_STATS_EN defined: add outputs hit_count and miss_count (32-bit each), incremented on IDLE lookups with rd_en=1 (hit/miss respectively), saturating at all-ones, cleared by reset and by flush.
REQ-027 ICACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-028 Shared package icache_pkg: DATA_LENGTH/LINE_SIZE/NUM_LINES defaults, derived WORDS/offset/index/tag widths, state enum (IDLE, FILL, DONE).
REQ-029 One sub-module icache_data_ram: NUM_LINES x WORDS x DATA_LENGTH array, one combinational read port, one synchronous write port; tags and valid bits stay in icache_array.

Verification
REQ-030 After reset, rd_en=1, addr_in=0x0000_1040 -> miss=1 same cycle, FILL next cycle.
REQ-031 Feed 16 refill words 0xA000_0000..0xA000_000F, refill_valid gapped every other cycle -> refill_complete one pulse after 16th word; rd_en=1, addr_in=0x0000_1048 -> miss=0, data_out=0xA000_0002.
REQ-032 Line resident at index 1, addr_in=0x0002_1040 (same index, different tag) -> miss=1; refill replaces line; 0x0000_1040 then misses.
REQ-033 flush asserted with the 16th refill_valid -> no refill_complete, state IDLE, 0x0000_1040 misses.
REQ-034 rst low after 8 refill words, then released -> 0x0000_1040 misses, counter restarts at 0.
REQ-035 With ICACHE_STATS_EN: 3 hits, 1 miss -> hit_count=3, miss_count=1; flush -> both 0.
